// File: rtl/uart_pkg.sv
// Shared UART definitions: config word layout, field constants and the
// arbiter state encoding used by the requester-sharing logic.
package uart_pkg;

    localparam int DATA_W = 16;
    localparam int CFG_W  = 27;

    localparam int CFG_PRESCALER_LSB = 0;
    localparam int CFG_PRESCALER_W   = 16;
    localparam int CFG_PARITY_LSB    = 16;
    localparam int CFG_PARITY_W      = 3;
    localparam int CFG_BYTE_SIZE_LSB = 19;
    localparam int CFG_BYTE_SIZE_W   = 4;
    localparam int CFG_STOP_BITS_BIT = 23;
    localparam int CFG_ENABLE_BIT    = 25;

    localparam logic [2:0] PARITY_NONE  = 3'd0;
    localparam logic [2:0] PARITY_EVEN  = 3'd1;
    localparam logic [2:0] PARITY_ODD   = 3'd2;
    localparam logic [2:0] PARITY_MARK  = 3'd3;
    localparam logic [2:0] PARITY_SPACE = 3'd4;

    localparam logic STOP_BITS_1 = 1'b0;
    localparam logic STOP_BITS_2 = 1'b1;

    // Field order mirrors the bit offsets above, MSB first.
    typedef struct packed {
        logic        rsvd26;
        logic        enable;
        logic        rsvd24;
        logic        stop_bits;
        logic [3:0]  byte_size;
        logic [2:0]  parity;
        logic [15:0] prescaler;
    } uart_cfg_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_DRAIN,
        ARB_CONFIG,
        ARB_STREAM
    } arb_state_e;

    function automatic int gnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after 'last',
// wrapping around and finally considering 'last' itself.
module uart_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] next,
    output logic         found
);

    logic [W-1:0] idx;

    always_comb begin
        idx   = '0;
        next  = last;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = W'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                next  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ AXI-Stream requesters, round-robin per
// packet, reloading the UART config (after draining it) when it changes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 0,
    localparam int GNT_W     = gnt_width(NUM_REQ)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [NUM_REQ*16-1:0]    s_axis_tdata,
    input  logic [NUM_REQ-1:0]       s_axis_tvalid,
    input  logic [NUM_REQ-1:0]       s_axis_tlast,
    output logic [NUM_REQ-1:0]       s_axis_tready,
    input  logic [NUM_REQ*CFG_W-1:0] req_cfg,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [CFG_W-1:0]         m_axis_config_tdata,
    output logic                     m_axis_config_tvalid,
    input  logic                     m_axis_config_tready,
    input  logic [31:0]              tx_data_count,
    output logic [GNT_W-1:0]         grant_id,
    output logic                     busy
);

    localparam logic [15:0] BURST_LAST = 16'(MAX_BURST - 1);

    arb_state_e state;
    uart_cfg_t  cfg_lat;
    uart_cfg_t  cur_cfg;
    logic       cur_cfg_valid;
    logic [15:0] beat_cnt;

    logic [NUM_REQ-1:0][DATA_W-1:0] tdata_arr;
    uart_cfg_t [NUM_REQ-1:0]        cfg_arr;
    logic [GNT_W-1:0] pick_id;
    logic             pick_found;
    logic             stream;
    logic             beat_hs;
    logic             burst_end;

    assign tdata_arr = s_axis_tdata;
    assign cfg_arr   = req_cfg;

    uart_rr_pick #(.N(NUM_REQ), .W(GNT_W)) u_pick (
        .req   (s_axis_tvalid),
        .last  (grant_id),
        .next  (pick_id),
        .found (pick_found)
    );

    // Data path is a pure pass-through of the granted lane while streaming.
    assign stream        = (state == ARB_STREAM);
    assign m_axis_tdata  = tdata_arr[grant_id];
    assign m_axis_tvalid = stream && s_axis_tvalid[grant_id];
    assign beat_hs       = m_axis_tvalid && m_axis_tready;
    assign burst_end     = (MAX_BURST != 0) && (beat_cnt == BURST_LAST);
    assign busy          = (state != ARB_IDLE);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign s_axis_tready[g] = stream && m_axis_tready && (grant_id == GNT_W'(g));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state                <= ARB_IDLE;
            grant_id             <= GNT_W'(NUM_REQ - 1);
            cfg_lat              <= '0;
            cur_cfg              <= '0;
            cur_cfg_valid        <= 1'b0;
            beat_cnt             <= '0;
            m_axis_config_tvalid <= 1'b0;
            m_axis_config_tdata  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_id;
                        cfg_lat  <= cfg_arr[pick_id];
                        beat_cnt <= '0;
                        state    <= (cur_cfg_valid && (cfg_arr[pick_id] == cur_cfg))
                                    ? ARB_STREAM : ARB_DRAIN;
                    end
                end
                // Config may only change once the UART has emptied its FIFO.
                ARB_DRAIN: begin
                    if ((tx_data_count == '0) && m_axis_config_tready) begin
                        m_axis_config_tvalid <= 1'b1;
                        m_axis_config_tdata  <= cfg_lat;
                        state                <= ARB_CONFIG;
                    end
                end
                ARB_CONFIG: begin
                    if (m_axis_config_tready) begin
                        cur_cfg              <= cfg_lat;
                        cur_cfg_valid        <= 1'b1;
                        m_axis_config_tvalid <= 1'b0;
                        state                <= ARB_STREAM;
                    end
                end
                ARB_STREAM: begin
                    if (beat_hs) begin
                        if (beat_cnt != '1) beat_cnt <= beat_cnt + 16'd1;
                        if (s_axis_tlast[grant_id] || burst_end) state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: packet-level scoreboard predicting grant order,
// config reloads and beat order for the shared uart_tx arbiter.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int MB = 4;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic [NR*16-1:0] s_axis_tdata = '0;
    logic [NR-1:0]    s_axis_tvalid = '0;
    logic [NR-1:0]    s_axis_tlast = '0;
    logic [NR-1:0]    s_axis_tready;
    logic [NR*27-1:0] req_cfg = '0;
    logic [15:0]      m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic [26:0]      m_axis_config_tdata;
    logic             m_axis_config_tvalid;
    logic             m_axis_config_tready = 1'b0;
    logic [31:0]      tx_data_count = '0;
    logic [1:0]       grant_id;
    logic             busy;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tready        (s_axis_tready),
        .req_cfg              (req_cfg),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tready        (m_axis_tready),
        .m_axis_config_tdata  (m_axis_config_tdata),
        .m_axis_config_tvalid (m_axis_config_tvalid),
        .m_axis_config_tready (m_axis_config_tready),
        .tx_data_count        (tx_data_count),
        .grant_id             (grant_id),
        .busy                 (busy)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    beat_t       src_q[NR][$];
    beat_t       exp_q[NR][$];
    logic [26:0] cfg_of[NR];
    logic [11:0] seq[NR];
    bit          pop[NR];
    int          tready_pct, crdy_pct, cnt_force;

    // Scoreboard state: last granted requester and config the UART holds.
    int          model_last;
    bit          loaded_v;
    logic [26:0] loaded;
    bit          seg_open;
    int          seg_id, seg_n;
    int          cfg_pend, cfg_total;
    logic [26:0] cfg_pend_val;
    logic [31:0] prev_cnt;
    logic        prev_rdy, prev_cfgv;
    int          hs_cyc[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NR; i++) s += exp_q[i].size();
        return s;
    endfunction

    function automatic int rr_next(input int last);
        for (int k = 1; k <= NR; k++)
            if (exp_q[(last + k) % NR].size() > 0) return (last + k) % NR;
        return -1;
    endfunction

    task automatic model_reset();
        model_last = NR - 1;
        loaded_v   = 1'b0;
        seg_open   = 1'b0;
        cfg_pend   = 0;
    endtask

    task automatic load(input int r, input int len, input logic [26:0] cfg);
        beat_t b;
        cfg_of[r] = cfg;
        for (int k = 0; k < len; k++) begin
            b.d = {4'(r), seq[r]};
            b.l = (k == len - 1);
            seq[r] = seq[r] + 12'd1;
            src_q[r].push_back(b);
            exp_q[r].push_back(b);
        end
    endtask

    task automatic monitor();
        int    n_s;
        int    e;
        beat_t b;
        n_s = 0;
        for (int i = 0; i < NR; i++)
            if (s_axis_tvalid[i] && s_axis_tready[i]) begin
                pop[i] = 1'b1;
                n_s++;
            end
        if (s_axis_tready != '0) chk("tready_onehot", 32'($countones(s_axis_tready)), 32'd1);
        if (n_s != 0 || (m_axis_tvalid && m_axis_tready))
            chk("hs_pair", 32'(n_s), {31'b0, m_axis_tvalid && m_axis_tready});
        if (m_axis_config_tvalid && !prev_cfgv)
            chk("cfg_after_drain", {30'b0, prev_cnt == 32'd0, prev_rdy}, 32'd3);
        if (m_axis_config_tvalid && m_axis_config_tready) begin
            chk("cfg_between_segs", {31'b0, seg_open}, 32'd0);
            cfg_pend++;
            cfg_total++;
            cfg_pend_val = m_axis_config_tdata;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (!seg_open) begin
                e = rr_next(model_last);
                if (e < 0) begin
                    chk("unexpected_beat", {16'b0, m_axis_tdata}, 32'hffff_ffff);
                end else begin
                    chk("seg_req", 32'(m_axis_tdata[15:12]), 32'(e));
                    chk("grant_id", 32'(grant_id), 32'(e));
                    if (loaded_v && loaded == cfg_of[e]) begin
                        chk("cfg_skipped", 32'(cfg_pend), 32'd0);
                    end else begin
                        chk("cfg_count", 32'(cfg_pend), 32'd1);
                        chk("cfg_value", 32'(cfg_pend_val), 32'(cfg_of[e]));
                    end
                    loaded   = cfg_of[e];
                    loaded_v = 1'b1;
                    cfg_pend = 0;
                    seg_open = 1'b1;
                    seg_id   = e;
                    seg_n    = 0;
                end
            end
            if (seg_open) begin
                b = exp_q[seg_id].pop_front();
                chk("beat", 32'(m_axis_tdata), 32'(b.d));
                seg_n++;
                if (b.l || seg_n == MB) begin
                    seg_open   = 1'b0;
                    model_last = seg_id;
                end
            end
            hs_cyc.push_back(cyc);
        end
        prev_cnt  = tx_data_count;
        prev_rdy  = m_axis_config_tready;
        prev_cfgv = m_axis_config_tvalid;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (pop[i]) begin
                void'(src_q[i].pop_front());
                pop[i] = 1'b0;
            end
            s_axis_tvalid[i] = (src_q[i].size() > 0);
            s_axis_tdata[16*i +: 16] = (src_q[i].size() > 0) ? src_q[i][0].d : 16'h0;
            s_axis_tlast[i] = (src_q[i].size() > 0) ? src_q[i][0].l : 1'b0;
            req_cfg[27*i +: 27] = cfg_of[i];
        end
        m_axis_tready        = ($urandom_range(99) < 32'(tready_pct));
        m_axis_config_tready = ($urandom_range(99) < 32'(crdy_pct));
        if (cnt_force >= 0) tx_data_count = 32'(cnt_force);
        else tx_data_count = ($urandom_range(9) < 6) ? 32'd0 : $urandom_range(20, 1);
        cyc++;
        @(negedge aclk);
        monitor();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((pending() > 0 || seg_open) && n < bound) begin
            step();
            n++;
        end
        chk("drain_done", 32'(pending()), 32'd0);
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_grant", 32'(grant_id), 32'(model_last));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, "_cfg_tvalid"}, 32'(m_axis_config_tvalid), 32'd0);
        chk({tag, "_cfg_tdata"}, 32'(m_axis_config_tdata), 32'd0);
        chk({tag, "_grant"}, 32'(grant_id), 32'(NR - 1));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [26:0] cfg_lut[3];
        logic [26:0] c;
        int t0, n0, n, any;
        cfg_lut[0] = 27'h00000C;
        cfg_lut[1] = 27'h10000C;
        cfg_lut[2] = 27'h0A1234;
        for (int i = 0; i < NR; i++) begin
            seq[i]    = '0;
            cfg_of[i] = '0;
            pop[i]    = 1'b0;
        end
        model_reset();
        cfg_total = 0;
        prev_cnt  = '0;
        prev_rdy  = 1'b0;
        prev_cfgv = 1'b0;
        tready_pct = 100;
        crdy_pct   = 100;
        cnt_force  = 0;

        repeat (3) step();
        chk_reset_outputs("rst");
        areset = 1'b0;

        // First packet ever: drain, one config beat, then the data.
        load(0, 3, 27'h00000C);
        drain(100);
        chk("p1_cfg_total", 32'(cfg_total), 32'd1);

        // Two requesters at once with the already-loaded config.
        hs_cyc.delete();
        t0 = cyc + 1;
        load(1, 2, 27'h00000C);
        load(2, 2, 27'h00000C);
        drain(100);
        chk("p2_beats", 32'(hs_cyc.size()), 32'd4);
        if (hs_cyc.size() == 4) begin
            chk("p2_latency", 32'(hs_cyc[0] - t0), 32'd1);
            chk("p2_gap", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
        end
        chk("p2_no_cfg", 32'(cfg_total), 32'd1);

        // Config change must wait for an empty FIFO and an idle UART.
        hs_cyc.delete();
        n0 = cfg_total;
        cnt_force = 5;
        load(3, 3, 27'h10000C);
        repeat (6) step();
        cnt_force = 0;
        crdy_pct  = 0;
        repeat (4) step();
        chk("p3_held_cfg", 32'(cfg_total - n0), 32'd0);
        chk("p3_held_data", 32'(hs_cyc.size()), 32'd0);
        chk("p3_busy", 32'(busy), 32'd1);
        chk("p3_grant", 32'(grant_id), 32'd3);
        crdy_pct = 100;
        drain(100);
        chk("p3_cfg", 32'(cfg_total - n0), 32'd1);

        // Long packet is cut after MAX_BURST beats so requester 1 gets a turn.
        hs_cyc.delete();
        load(0, 7, 27'h10000C);
        load(1, 2, 27'h10000C);
        drain(200);
        chk("p4_beats", 32'(hs_cyc.size()), 32'd9);
        if (hs_cyc.size() == 9) chk("p4_gap_at_cut", 32'(hs_cyc[4] - hs_cyc[3]), 32'd2);

        // Randomised rounds: backpressure, config stalls, FIFO occupancy.
        for (int r = 0; r < 12; r++) begin
            tready_pct = $urandom_range(100, 30);
            crdy_pct   = $urandom_range(100, 40);
            cnt_force  = -1;
            any = 0;
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(1) == 1 || (i == NR - 1 && any == 0)) begin
                    c = cfg_lut[$urandom_range(2)];
                    n = $urandom_range(2, 1);
                    for (int p = 0; p < n; p++) load(i, $urandom_range(6, 1), c);
                    any = 1;
                end
            end
            drain(3000);
        end

        // Reset mid-packet: the rest of the packet re-arbitrates with a fresh config.
        tready_pct = 100;
        crdy_pct   = 100;
        cnt_force  = 0;
        hs_cyc.delete();
        load(2, 6, 27'h2083E8);
        n = 0;
        while (hs_cyc.size() < 2 && n < 50) begin
            step();
            n++;
        end
        chk("p6_started", 32'(hs_cyc.size()), 32'd2);
        tready_pct = 0;
        areset = 1'b1;
        step();
        chk_reset_outputs("p6_rst");
        model_reset();
        areset = 1'b0;
        n0 = cfg_total;
        tready_pct = 100;
        drain(100);
        chk("p6_recfg", 32'(cfg_total - n0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
